// File: rtl/fetch_decode_buffer.sv
// Two-entry elastic buffer between fetch and decode: holds {pc, instr} pairs in
// FIFO order, absorbs decode stalls and supports a synchronous redirect flush.
module fetch_decode_buffer #(
    parameter int                 DATA_W = 32,
    parameter logic [DATA_W-1:0]  NOP    = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_instr,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_instr,
    input  logic              out_ready,
    input  logic              flush,
    output logic [1:0]        count
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]        r_count;
    logic [DATA_W-1:0] r_headPc;
    logic [DATA_W-1:0] r_headInstr;
    logic [DATA_W-1:0] r_tailPc;
    logic [DATA_W-1:0] r_tailInstr;
    logic              w_push;
    logic              w_pop;

    // Handshake flags come only from registered occupancy, so decode's ready
    // never reaches fetch's ready combinationally.
    assign in_ready  = (r_count != FULL);
    assign out_valid = (r_count != EMPTY);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign count     = r_count;
    assign out_pc    = out_valid ? r_headPc    : '0;
    assign out_instr = out_valid ? r_headInstr : NOP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= EMPTY;
            r_headPc    <= '0;
            r_headInstr <= NOP;
            r_tailPc    <= '0;
            r_tailInstr <= NOP;
        end else if (flush) begin
            r_count     <= EMPTY;
            r_headPc    <= '0;
            r_headInstr <= NOP;
            r_tailPc    <= '0;
            r_tailInstr <= NOP;
        end else begin
            case (r_count)
                EMPTY: begin
                    if (w_push) begin
                        r_headPc    <= in_pc;
                        r_headInstr <= in_instr;
                        r_count     <= ONE;
                    end
                end
                ONE: begin
                    // Push with pop overwrites head directly for back-to-back flow.
                    if (w_push && w_pop) begin
                        r_headPc    <= in_pc;
                        r_headInstr <= in_instr;
                    end else if (w_push) begin
                        r_tailPc    <= in_pc;
                        r_tailInstr <= in_instr;
                        r_count     <= FULL;
                    end else if (w_pop) begin
                        r_count     <= EMPTY;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        r_headPc    <= r_tailPc;
                        r_headInstr <= r_tailInstr;
                        r_count     <= ONE;
                    end
                end
                default: begin
                    r_count <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Self-checking bench for fetch_decode_buffer: directed vector table, hand-written
// reset/flush sequences, and random traffic against a queue-based model.
module tb_fetch_decode_buffer;

    localparam logic [31:0] NOP = 32'h00000000;

    logic        clk;
    logic        rst_n;
    logic        inValid;
    logic [31:0] inPc;
    logic [31:0] inInstr;
    logic        inReady;
    logic        outValid;
    logic [31:0] outPc;
    logic [31:0] outInstr;
    logic        outReady;
    logic        flush;
    logic [1:0]  count;

    int passCount = 0;
    int totalCount = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } pair_t;

    typedef struct packed {
        logic        inValid;
        logic [31:0] inPc;
        logic [31:0] inInstr;
        logic        outReady;
        logic        flush;
        logic [1:0]  expCount;
        logic        expOutValid;
        logic        expInReady;
        logic [31:0] expOutPc;
        logic [31:0] expOutInstr;
    } vec_t;

    vec_t  vecs[17];
    pair_t modelQ[$];

    fetch_decode_buffer #(.DATA_W(32), .NOP(NOP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inValid),
        .in_pc     (inPc),
        .in_instr  (inInstr),
        .in_ready  (inReady),
        .out_valid (outValid),
        .out_pc    (outPc),
        .out_instr (outInstr),
        .out_ready (outReady),
        .flush     (flush),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkVec(logic iv, logic [31:0] pc, logic [31:0] ins, logic ordy,
                                   logic fl, logic [1:0] ec, logic eov, logic eir,
                                   logic [31:0] epc, logic [31:0] eins);
        vec_t v;
        v.inValid     = iv;
        v.inPc        = pc;
        v.inInstr     = ins;
        v.outReady    = ordy;
        v.flush       = fl;
        v.expCount    = ec;
        v.expOutValid = eov;
        v.expInReady  = eir;
        v.expOutPc    = epc;
        v.expOutInstr = eins;
        return v;
    endfunction

    task automatic applyStimulus(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                                 input logic ordy, input logic fl);
        inValid  = iv;
        inPc     = pc;
        inInstr  = ins;
        outReady = ordy;
        flush    = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [1:0] expCount, input logic expOv,
                               input logic expIr, input logic [31:0] expPc, input logic [31:0] expInstr);
        totalCount++;
        if (count === expCount && outValid === expOv && inReady === expIr &&
            outPc === expPc && outInstr === expInstr) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got count=%0d ov=%b ir=%b pc=%h instr=%h, want count=%0d ov=%b ir=%b pc=%h instr=%h",
                     name, count, outValid, inReady, outPc, outInstr,
                     expCount, expOv, expIr, expPc, expInstr);
        end
    endtask

    // Abstract model: a bounded queue of pairs; flush empties it, otherwise pop then push.
    task automatic modelStep(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                             input logic ordy, input logic fl);
        pair_t p;
        logic  canPush;
        logic  canPop;
        canPush = (modelQ.size() < 2);
        canPop  = (modelQ.size() > 0);
        if (fl) begin
            modelQ.delete();
        end else begin
            if (canPop && ordy) void'(modelQ.pop_front());
            if (canPush && iv) begin
                p.pc    = pc;
                p.instr = ins;
                modelQ.push_back(p);
            end
        end
    endtask

    task automatic checkModel(input string name);
        if (modelQ.size() > 0)
            checkOutput(name, 2'(modelQ.size()), 1'b1, modelQ.size() != 2, modelQ[0].pc, modelQ[0].instr);
        else
            checkOutput(name, 2'd0, 1'b0, 1'b1, 32'h0, NOP);
    endtask

    initial begin
        logic        iv;
        logic        ordy;
        logic        fl;
        logic [31:0] pc;
        logic [31:0] ins;

        // Streaming, stall, push+pop at ONE, and flush scenarios with hand-derived results.
        vecs[0]  = mkVec(1, 32'h00, 32'h20080005, 1, 0, 2'd1, 1, 1, 32'h00, 32'h20080005);
        vecs[1]  = mkVec(1, 32'h04, 32'h20090003, 1, 0, 2'd1, 1, 1, 32'h04, 32'h20090003);
        vecs[2]  = mkVec(1, 32'h08, 32'h01095020, 1, 0, 2'd1, 1, 1, 32'h08, 32'h01095020);
        vecs[3]  = mkVec(0, 32'h00, 32'h00000000, 1, 0, 2'd0, 0, 1, 32'h00, NOP);
        vecs[4]  = mkVec(1, 32'h00, 32'h20080005, 0, 0, 2'd1, 1, 1, 32'h00, 32'h20080005);
        vecs[5]  = mkVec(1, 32'h04, 32'h20090003, 0, 0, 2'd2, 1, 0, 32'h00, 32'h20080005);
        vecs[6]  = mkVec(1, 32'h08, 32'h01095020, 0, 0, 2'd2, 1, 0, 32'h00, 32'h20080005);
        vecs[7]  = mkVec(1, 32'h08, 32'h01095020, 1, 0, 2'd1, 1, 1, 32'h04, 32'h20090003);
        vecs[8]  = mkVec(1, 32'h08, 32'h01095020, 1, 0, 2'd1, 1, 1, 32'h08, 32'h01095020);
        vecs[9]  = mkVec(0, 32'h00, 32'h00000000, 1, 0, 2'd0, 0, 1, 32'h00, NOP);
        vecs[10] = mkVec(1, 32'h10, 32'hAAAA0010, 0, 0, 2'd1, 1, 1, 32'h10, 32'hAAAA0010);
        vecs[11] = mkVec(1, 32'h14, 32'hAAAA0014, 1, 0, 2'd1, 1, 1, 32'h14, 32'hAAAA0014);
        vecs[12] = mkVec(0, 32'h00, 32'h00000000, 1, 0, 2'd0, 0, 1, 32'h00, NOP);
        vecs[13] = mkVec(1, 32'h20, 32'hBBBB0020, 0, 0, 2'd1, 1, 1, 32'h20, 32'hBBBB0020);
        vecs[14] = mkVec(1, 32'h24, 32'hBBBB0024, 0, 0, 2'd2, 1, 0, 32'h20, 32'hBBBB0020);
        vecs[15] = mkVec(1, 32'h28, 32'hBBBB0028, 0, 1, 2'd0, 0, 1, 32'h00, NOP);
        vecs[16] = mkVec(0, 32'h00, 32'h00000000, 1, 0, 2'd0, 0, 1, 32'h00, NOP);

        rst_n = 1'b0;
        applyStimulus(1'b1, 32'h100, 32'hDEADBEEF, 1'b1, 1'b0);
        #1;
        checkOutput("reset_t0", 2'd0, 1'b0, 1'b1, 32'h0, NOP);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("reset_hold%0d", i), 2'd0, 1'b0, 1'b1, 32'h0, NOP);
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].inValid, vecs[i].inPc, vecs[i].inInstr, vecs[i].outReady, vecs[i].flush);
            tick();
            checkOutput($sformatf("vec%0d", i), vecs[i].expCount, vecs[i].expOutValid,
                        vecs[i].expInReady, vecs[i].expOutPc, vecs[i].expOutInstr);
        end

        // Asynchronous reset while FULL must clear without a clock edge.
        applyStimulus(1'b1, 32'h30, 32'hCCCC0030, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h34, 32'hCCCC0034, 1'b0, 1'b0);
        tick();
        checkOutput("pre_async_full", 2'd2, 1'b1, 1'b0, 32'h30, 32'hCCCC0030);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 2'd0, 1'b0, 1'b1, 32'h0, NOP);
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b1, 32'h40, 32'hDDDD0040, 1'b0, 1'b0);
        tick();
        checkOutput("post_reset_push", 2'd1, 1'b1, 1'b1, 32'h40, 32'hDDDD0040);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("post_reset_drain", 2'd0, 1'b0, 1'b1, 32'h0, NOP);

        modelQ.delete();
        for (int i = 0; i < 400; i++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 15) == 0);
            pc   = $urandom;
            ins  = $urandom;
            applyStimulus(iv, pc, ins, ordy, fl);
            modelStep(iv, pc, ins, ordy, fl);
            tick();
            checkModel($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
